// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_pkg
//  Purpose  : Shared dimensions, lane slicing and FSM encoding for the
//             systolic array feeder.
//  Revision : 1.0  initial release
// ============================================================================
package systolic_pkg;

    // Array dimension (rows = cols = reduction depth) and element width
    localparam int N      = 8;
    localparam int DATA_W = 16;

    // One lane of a beat / output bus is one element
    localparam int LANE_W = DATA_W;
    localparam int BUS_W  = N * LANE_W;

    // Step counter covers 0..2N-2, beat counter covers 0..2N-1
    localparam int T_W = $clog2(2 * N);
    localparam int B_W = $clog2(2 * N);

    // Feeder FSM encoding
    localparam int         ST_W      = 2;
    localparam logic [1:0] ST_LOAD   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    // Extract lane k from a packed N-lane word
    function automatic logic [LANE_W-1:0] get_lane(input logic [BUS_W-1:0] w, input int k);
        return w[k*LANE_W +: LANE_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_feeder_if
//  Purpose  : Loader handshake and array-facing bus of the systolic feeder.
//             master = loader/array side, slave = feeder.
//  Revision : 1.0  initial release
// ============================================================================
interface systolic_feeder_if #(
    parameter int N      = systolic_pkg::N,
    parameter int DATA_W = systolic_pkg::DATA_W
);
    logic                in_valid;
    logic                in_ready;
    logic [N*DATA_W-1:0] in_data;
    logic [N*DATA_W-1:0] act_out;
    logic [N*DATA_W-1:0] wgt_out;
    logic [N-1:0]        row_done;
    logic                array_en;
    logic                busy;
    logic                batch_done;

    modport master (
        output in_valid, in_data,
        input  in_ready, act_out, wgt_out, row_done, array_en, busy, batch_done
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, act_out, wgt_out, row_done, array_en, busy, batch_done
    );
endinterface
`default_nettype wire

// File: rtl/systolic_skew_lane.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_skew_lane
//  Purpose  : Selects the element a lane presents at step t. The lane with
//             index L emits element (t-L) of its N stored elements while
//             L <= t < L+N, and zero otherwise. The done flag marks the step
//             carrying the lane's last element (t = L+N-1).
//  Revision : 1.0  initial release
// ============================================================================
module systolic_skew_lane
    import systolic_pkg::*;
(
    input  wire logic [BUS_W-1:0]  i_elems,
    input  wire logic [T_W-1:0]    i_t,
    input  wire logic [T_W-1:0]    i_lane,
    output logic      [LANE_W-1:0] o_elem,
    output logic                   o_done
);

    // One extra bit so lane+N cannot wrap
    logic [T_W:0]   w_t_ext;
    logic [T_W:0]   w_lo;
    logic [T_W:0]   w_hi;
    logic [T_W:0]   w_last;
    logic           w_in_window;
    logic [T_W-1:0] w_idx;

    assign w_t_ext     = {1'b0, i_t};
    assign w_lo        = {1'b0, i_lane};
    assign w_hi        = w_lo + (T_W+1)'(N);
    assign w_last      = w_hi - (T_W+1)'(1);
    assign w_in_window = (w_t_ext >= w_lo) && (w_t_ext < w_hi);
    assign w_idx       = i_t - i_lane;
    assign o_done      = (w_t_ext == w_last);

    // Mux the element at offset t-lane; zero outside the skew window
    always_comb begin
        o_elem = '0;
        for (int k = 0; k < N; k++) begin
            if (w_in_window && (w_idx == T_W'(k))) begin
                o_elem = get_lane(i_elems, k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/systolic_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_feeder
//  Purpose  : Collects an N x N activation matrix A (rows) and weight matrix
//             B (columns) from a valid/ready loader, then streams them into an
//             output-stationary systolic array with diagonal skew, followed by
//             a drain window with the array still enabled.
//  Revision : 1.0  initial release
// ============================================================================
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int DRAIN_CYCLES = 16
) (
    input wire logic           clk,
    input wire logic           rst_n,
    systolic_feeder_if.slave   bus
);

    localparam int D_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [B_W-1:0] C_LAST_BEAT  = B_W'(2 * N - 1);
    localparam logic [T_W-1:0] C_LAST_STEP  = T_W'(2 * N - 2);
    localparam logic [D_W-1:0] C_LAST_DRAIN = D_W'(DRAIN_CYCLES - 1);

    // FSM and counters
    logic [ST_W-1:0] r_state;
    logic [ST_W-1:0] w_state_nxt;
    logic [B_W-1:0]  r_beat;
    logic [B_W-1:0]  w_beat_nxt;
    logic [T_W-1:0]  r_t;
    logic [T_W-1:0]  w_t_nxt;
    logic [D_W-1:0]  r_drain;
    logic [D_W-1:0]  w_drain_nxt;

    // Beat storage: r_a[i] is row i of A, r_b[j] is column j of B. A column
    // of B arrives as a single beat, so each lane indexes its own word.
    logic [BUS_W-1:0] r_a [N];
    logic [BUS_W-1:0] r_b [N];

    // Registered outputs and their next values
    logic             r_in_ready, w_in_ready_nxt;
    logic [BUS_W-1:0] r_act,      w_act_nxt;
    logic [BUS_W-1:0] r_wgt,      w_wgt_nxt;
    logic [N-1:0]     r_row_done, w_row_done_nxt;
    logic             r_array_en, w_array_en_nxt;
    logic             r_busy,     w_busy_nxt;
    logic             r_batch_done, w_batch_done_nxt;

    // Lane selections for the step about to be presented
    logic [LANE_W-1:0] w_act_lane [N];
    logic [LANE_W-1:0] w_wgt_lane [N];
    logic [N-1:0]      w_act_done;
    logic [N-1:0]      w_wgt_done;

    // in_ready is only high in LOAD, so it alone qualifies a transfer
    logic w_xfer;
    assign w_xfer = bus.in_valid & r_in_ready;

    // State register: FSM and counters, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LOAD;
            r_beat  <= '0;
            r_t     <= '0;
            r_drain <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            r_t     <= w_t_nxt;
            r_drain <= w_drain_nxt;
        end
    end

    // Next-state logic: LOAD counts beats, STREAM counts steps, DRAIN counts idle cycles
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_t_nxt     = r_t;
        w_drain_nxt = r_drain;
        case (r_state)
            ST_LOAD: begin
                if (w_xfer) begin
                    if (r_beat == C_LAST_BEAT) begin
                        w_state_nxt = ST_STREAM;
                        w_beat_nxt  = '0;
                        w_t_nxt     = '0;
                    end else begin
                        w_beat_nxt = r_beat + B_W'(1);
                    end
                end
            end
            ST_STREAM: begin
                if (r_t == C_LAST_STEP) begin
                    w_state_nxt = ST_DRAIN;
                    w_t_nxt     = '0;
                    w_drain_nxt = '0;
                end else begin
                    w_t_nxt = r_t + T_W'(1);
                end
            end
            ST_DRAIN: begin
                if (r_drain == C_LAST_DRAIN) begin
                    w_state_nxt = ST_LOAD;
                    w_drain_nxt = '0;
                end else begin
                    w_drain_nxt = r_drain + D_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_LOAD;
                w_beat_nxt  = '0;
                w_t_nxt     = '0;
                w_drain_nxt = '0;
            end
        endcase
    end

    // Beat storage: beats 0..N-1 fill A rows, beats N..2N-1 fill B columns
    always_ff @(posedge clk) begin
        if (w_xfer) begin
            for (int k = 0; k < N; k++) begin
                if (r_beat == B_W'(k)) begin
                    r_a[k] <= bus.in_data;
                end
                if (r_beat == B_W'(N + k)) begin
                    r_b[k] <= bus.in_data;
                end
            end
        end
    end

    generate
        for (genvar i = 0; i < N; i++) begin : g_lane
            systolic_skew_lane u_act (
                .i_elems (r_a[i]),
                .i_t     (w_t_nxt),
                .i_lane  (T_W'(i)),
                .o_elem  (w_act_lane[i]),
                .o_done  (w_act_done[i])
            );
            systolic_skew_lane u_wgt (
                .i_elems (r_b[i]),
                .i_t     (w_t_nxt),
                .i_lane  (T_W'(i)),
                .o_elem  (w_wgt_lane[i]),
                .o_done  (w_wgt_done[i])
            );
        end
    endgenerate

    // Output logic: values for the cycle the FSM is entering
    always_comb begin
        w_act_nxt        = '0;
        w_wgt_nxt        = '0;
        w_row_done_nxt   = '0;
        w_in_ready_nxt   = (w_state_nxt == ST_LOAD);
        w_busy_nxt       = (w_state_nxt != ST_LOAD);
        w_array_en_nxt   = (w_state_nxt != ST_LOAD);
        w_batch_done_nxt = (r_state == ST_DRAIN) && (w_state_nxt == ST_LOAD);
        if (w_state_nxt == ST_STREAM) begin
            for (int i = 0; i < N; i++) begin
                w_act_nxt[i*LANE_W +: LANE_W] = w_act_lane[i];
                w_wgt_nxt[i*LANE_W +: LANE_W] = w_wgt_lane[i];
            end
            // Row i's last A element and column i's last B element land on
            // the same step, so both lane flags agree
            w_row_done_nxt = w_act_done & w_wgt_done;
        end
    end

    // Output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready   <= 1'b0;
            r_act        <= '0;
            r_wgt        <= '0;
            r_row_done   <= '0;
            r_array_en   <= 1'b0;
            r_busy       <= 1'b0;
            r_batch_done <= 1'b0;
        end else begin
            r_in_ready   <= w_in_ready_nxt;
            r_act        <= w_act_nxt;
            r_wgt        <= w_wgt_nxt;
            r_row_done   <= w_row_done_nxt;
            r_array_en   <= w_array_en_nxt;
            r_busy       <= w_busy_nxt;
            r_batch_done <= w_batch_done_nxt;
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.act_out    = r_act;
    assign bus.wgt_out    = r_wgt;
    assign bus.row_done   = r_row_done;
    assign bus.array_en   = r_array_en;
    assign bus.busy       = r_busy;
    assign bus.batch_done = r_batch_done;

endmodule
`default_nettype wire

// File: tb/tb_systolic_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_systolic_feeder
//  Purpose  : Self-checking bench for systolic_feeder against a matrix-level
//             reference model of the skewed stream.
//  Revision : 1.0  initial release
// ============================================================================
module tb_systolic_feeder;
    import systolic_pkg::*;

    localparam int DRAIN = 16;
    localparam int NB    = 2 * N;
    localparam int SW    = 2 * N - 1;
    localparam int DW    = DATA_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    systolic_feeder_if bus ();

    systolic_feeder #(.DRAIN_CYCLES(DRAIN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: beats of the batch and the matrices they describe
    logic [BUS_W-1:0] beats [NB];
    logic [DW-1:0]    ma [N][N];
    logic [DW-1:0]    mb [N][N];
    logic [BUS_W-1:0] cap_act [SW];
    logic [BUS_W-1:0] cap_wgt [SW];
    logic [BUS_W-1:0] id_act  [SW];
    logic [BUS_W-1:0] id_wgt  [SW];

    task automatic build_model();
        for (int b = 0; b < NB; b++)
            for (int k = 0; k < N; k++)
                if (b < N) ma[b][k]   = beats[b][k*DW +: DW];
                else       mb[k][b-N] = beats[b][k*DW +: DW];
    endtask

    task automatic set_identity();
        for (int b = 0; b < NB; b++)
            for (int k = 0; k < N; k++)
                if (b < N) beats[b][k*DW +: DW] = (k == b) ? DW'(1) : DW'(0);
                else       beats[b][k*DW +: DW] = DW'(b - N + 1);
    endtask

    task automatic set_random();
        for (int b = 0; b < NB; b++)
            for (int k = 0; k < N; k++)
                beats[b][k*DW +: DW] = DW'($urandom);
    endtask

    function automatic logic [BUS_W-1:0] seq_beat(input int s);
        logic [BUS_W-1:0] w;
        for (int k = 0; k < N; k++) w[k*DW +: DW] = DW'(s * 16 + k);
        return w;
    endfunction

    // Offer the model's beats; mode 0 = valid every cycle, 1 = toggling from 0
    task automatic load_batch(input int mode, input logic keep, output int cycles);
        int   idx;
        logic vld, rdy;
        idx    = 0;
        cycles = 0;
        while (idx < NB && cycles < 200) begin
            vld          = (mode == 0) ? 1'b1 : ((cycles % 2) == 1);
            bus.in_valid = vld;
            bus.in_data  = beats[idx];
            rdy          = bus.in_ready;
            @(posedge clk); #1;
            if (vld && rdy) idx++;
            cycles++;
            if (cycles == 1) begin
                checks++;
                if (bus.batch_done !== 1'b0) begin
                    errors++;
                    $display("FAIL load_batch_done_low got=%b exp=0", bus.batch_done);
                end
            end
        end
        checks++;
        if (idx != NB) begin
            errors++;
            $display("FAIL load_timeout beats=%0d exp=%0d", idx, NB);
        end
        if (!keep) bus.in_valid = 1'b0;
    endtask

    // Called at the first STREAM cycle; returns in the first LOAD cycle after DRAIN
    task automatic check_stream(input logic hold, input logic [BUS_W-1:0] next0);
        logic [BUS_W-1:0] ea, ew, junk;
        logic [N-1:0]     erd;
        logic             een, ebd;
        for (int cyc = 0; cyc <= SW + DRAIN; cyc++) begin
            if (hold) begin
                bus.in_valid = 1'b1;
                if (cyc == SW + DRAIN) bus.in_data = next0;
                else begin
                    for (int k = 0; k < N; k++) junk[k*DW +: DW] = DW'($urandom);
                    bus.in_data = junk;
                end
            end
            ea = '0; ew = '0; erd = '0;
            if (cyc < SW) begin
                for (int i = 0; i < N; i++) begin
                    if (cyc - i >= 0 && cyc - i < N) begin
                        ea[i*DW +: DW] = ma[i][cyc-i];
                        ew[i*DW +: DW] = mb[cyc-i][i];
                    end
                    if (cyc == i + N - 1) erd[i] = 1'b1;
                end
            end
            een = (cyc < SW + DRAIN);
            ebd = (cyc == SW + DRAIN);
            checks += 6;
            if (bus.act_out !== ea) begin
                errors++; $display("FAIL stream_act cyc=%0d got=%h exp=%h", cyc, bus.act_out, ea);
            end
            if (bus.wgt_out !== ew) begin
                errors++; $display("FAIL stream_wgt cyc=%0d got=%h exp=%h", cyc, bus.wgt_out, ew);
            end
            if (bus.row_done !== erd) begin
                errors++; $display("FAIL stream_row_done cyc=%0d got=%b exp=%b", cyc, bus.row_done, erd);
            end
            if (bus.array_en !== een || bus.busy !== een) begin
                errors++; $display("FAIL stream_en_busy cyc=%0d got=%b%b exp=%b%b", cyc, bus.array_en, bus.busy, een, een);
            end
            if (bus.batch_done !== ebd) begin
                errors++; $display("FAIL stream_batch_done cyc=%0d got=%b exp=%b", cyc, bus.batch_done, ebd);
            end
            if (bus.in_ready !== ebd) begin
                errors++; $display("FAIL stream_in_ready cyc=%0d got=%b exp=%b", cyc, bus.in_ready, ebd);
            end
            if (cyc < SW) begin
                cap_act[cyc] = bus.act_out;
                cap_wgt[cyc] = bus.wgt_out;
            end
            if (cyc < SW + DRAIN) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        rst_n        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0 || bus.array_en !== 1'b0 ||
            bus.batch_done !== 1'b0 || bus.act_out !== '0 || bus.wgt_out !== '0 || bus.row_done !== '0) begin
            errors++;
            $display("FAIL reset_outputs rdy=%b busy=%b en=%b bd=%b exp all 0", bus.in_ready, bus.busy, bus.array_en, bus.batch_done);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready got=%b exp=1", bus.in_ready);
        end
    endtask

    task automatic test_identity();
        int               cycles;
        logic [BUS_W-1:0] e;
        set_identity();
        build_model();
        load_batch(0, 1'b0, cycles);
        checks++;
        if (cycles != NB) begin
            errors++; $display("FAIL identity_load_cycles got=%0d exp=%0d", cycles, NB);
        end
        check_stream(1'b0, '0);
        e = '0; e[0 +: DW] = DW'(1);
        checks += 5;
        if (cap_act[0] !== e) begin errors++; $display("FAIL identity_t0_act got=%h exp=%h", cap_act[0], e); end
        if (cap_wgt[0] !== e) begin errors++; $display("FAIL identity_t0_wgt got=%h exp=%h", cap_wgt[0], e); end
        if (cap_act[7][7*DW +: DW] !== DW'(0)) begin
            errors++; $display("FAIL identity_t7_act7 got=%h exp=0", cap_act[7][7*DW +: DW]);
        end
        if (cap_act[14][7*DW +: DW] !== DW'(1)) begin
            errors++; $display("FAIL identity_t14_act7 got=%h exp=1", cap_act[14][7*DW +: DW]);
        end
        if (cap_wgt[14][7*DW +: DW] !== DW'(8)) begin
            errors++; $display("FAIL identity_t14_wgt7 got=%h exp=8", cap_wgt[14][7*DW +: DW]);
        end
        for (int t = 0; t < SW; t++) begin
            id_act[t] = cap_act[t];
            id_wgt[t] = cap_wgt[t];
        end
    endtask

    task automatic test_toggle_valid();
        int cycles;
        set_identity();
        build_model();
        load_batch(1, 1'b0, cycles);
        checks++;
        if (cycles != 2 * NB) begin
            errors++; $display("FAIL toggle_load_cycles got=%0d exp=%0d", cycles, 2 * NB);
        end
        check_stream(1'b0, '0);
        for (int t = 0; t < SW; t++) begin
            checks++;
            if (cap_act[t] !== id_act[t] || cap_wgt[t] !== id_wgt[t]) begin
                errors++; $display("FAIL toggle_vs_b2b t=%0d got=%h exp=%h", t, cap_act[t], id_act[t]);
            end
        end
    endtask

    task automatic test_random();
        int cycles, mode;
        for (int r = 0; r < 3; r++) begin
            mode = r % 2;
            set_random();
            build_model();
            load_batch(mode, 1'b0, cycles);
            checks++;
            if (cycles != (mode == 0 ? NB : 2 * NB)) begin
                errors++; $display("FAIL random_load_cycles r=%0d got=%0d", r, cycles);
            end
            check_stream(1'b0, '0);
        end
    endtask

    task automatic test_reset_mid_stream();
        int cycles;
        set_random();
        build_model();
        load_batch(0, 1'b0, cycles);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.act_out !== '0 || bus.wgt_out !== '0 || bus.row_done !== '0 || bus.array_en !== 1'b0 ||
            bus.busy !== 1'b0 || bus.batch_done !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_outputs en=%b busy=%b rdy=%b act=%h exp all 0", bus.array_en, bus.busy, bus.in_ready, bus.act_out);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_held_ready got=%b exp=0", bus.in_ready);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL reset_release rdy=%b busy=%b exp=1 0", bus.in_ready, bus.busy);
        end
        // Partial load that must be discarded by a reset
        bus.in_valid = 1'b1;
        repeat (5) begin
            bus.in_data = {N{DW'($urandom)}};
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        set_random();
        build_model();
        load_batch(1, 1'b0, cycles);
        checks++;
        if (cycles != 2 * NB) begin
            errors++; $display("FAIL after_reset_load_cycles got=%0d exp=%0d", cycles, 2 * NB);
        end
        check_stream(1'b0, '0);
    endtask

    task automatic test_back_to_back();
        int cycles;
        for (int b = 0; b < NB; b++) beats[b] = seq_beat(b);
        build_model();
        load_batch(0, 1'b1, cycles);
        checks++;
        if (cycles != NB) begin
            errors++; $display("FAIL b2b_first_load_cycles got=%0d exp=%0d", cycles, NB);
        end
        check_stream(1'b1, seq_beat(NB));
        for (int b = 0; b < NB; b++) beats[b] = seq_beat(NB + b);
        build_model();
        load_batch(0, 1'b0, cycles);
        checks++;
        if (cycles != NB) begin
            errors++; $display("FAIL b2b_second_load_cycles got=%0d exp=%0d", cycles, NB);
        end
        check_stream(1'b0, '0);
    endtask

    initial begin
        test_reset();
        test_identity();
        test_toggle_valid();
        test_random();
        test_reset_mid_stream();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 Parameter N, 8, array dimension (rows = cols = reduction depth).
REQ-002 Parameter DATA_W, 16, element width.
REQ-003 Parameter DRAIN_CYCLES, 16, cycles `array_en` stays high after the last skewed beat.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  loader beat valid.
REQ-007 in_ready  output  1  feeder can accept a beat.
REQ-008 in_data  input  N*DATA_W  one beat: lane k at bits [(k+1)*DATA_W-1 : k*DATA_W].
REQ-009 act_out  output  N*DATA_W  skewed activations; lane i drives array row i.
REQ-010 wgt_out  output  N*DATA_W  skewed weights; lane j drives array column j.
REQ-011 row_done  output  N  per-row last-element marker into the array's done inputs.
REQ-012 array_en  output  1  array enable; low clears the array.
REQ-013 busy  output  1  high in STREAM or DRAIN.
REQ-014 batch_done  output  1  one-cycle pulse at batch completion.

Function
REQ-015 FSM states: LOAD, STREAM, DRAIN; beat counter b (0..2N-1); step counter t.
REQ-016 LOAD: in_ready=1. A beat transfers when in_valid and in_ready are high on the same edge.
REQ-017 Beats b=0..N-1 store A row b (A[b][k] = lane k); beats b=N..2N-1 store B column b-N (B[k][b-N] = lane k).
REQ-018 On the 2N-th transfer: next cycle is STREAM with t=0; b returns to 0; in_ready drops in that cycle.
REQ-019 in_valid outside LOAD is ignored; in_data is never sampled outside LOAD.
REQ-020 STREAM lasts 2N-1 cycles, t=0..2N-2.
REQ-021 In the STREAM cycle with step t:
- act_out lane i = A[i][t-i] if 0<=t-i<N, else 0.
- wgt_out lane j = B[t-j][j] under the same bound, else 0.
- All are registered outputs.
REQ-022 row_done[i]=1 only in the STREAM cycle t=i+N-1; 0 otherwise.
REQ-023 array_en=1 from the first STREAM cycle through the last DRAIN cycle; 0 in LOAD.
REQ-024 DRAIN lasts DRAIN_CYCLES cycles. During DRAIN, act_out, wgt_out and row_done are 0.
REQ-025 After the last DRAIN cycle the FSM enters LOAD. batch_done=1 for exactly that first LOAD cycle.
REQ-026 A/B storage persists after a batch; the next batch overwrites all 2N entries.
REQ-027 in_valid held high continuously across batches: beats resume only after the return to LOAD, with no loss and no duplication.
REQ-028 No arithmetic is performed; data passes bit-exact.

Reset
REQ-029 rst_n low at any time (including mid-LOAD, STREAM or DRAIN) immediately forces:
- FSM to LOAD, b=0, t=0.
- act_out, wgt_out, row_done, array_en, busy and batch_done to 0.
- in_ready to 0.
REQ-030 A partially loaded batch is discarded on reset. in_ready=1 from the first clock edge after rst_n deasserts.
REQ-031 A/B storage need not be reset.

Structure
REQ-032 Shared package systolic_pkg holds N, DATA_W, the FSM state encoding, and the lane slice width.
REQ-033 Sub-module systolic_skew_lane, one instance per lane per direction:
- Inputs: N stored elements, t, lane index.
- Outputs: the skewed element and the lane's done flag.

Verification
REQ-034 Load A=identity, B[k][c]=c+1, then observe the stream:
- t=0: act lane0=1, wgt lane0=1, all other lanes 0.
- t=7: act lane7=0.
- t=14: act lane7=1, wgt lane7=8.
REQ-035 Load with in_valid toggled 1/0 every cycle:
- LOAD occupies 32 cycles.
- Stream is identical to the back-to-back case.
REQ-036 row_done check:
- Exactly one pulse per row, row_done[i] at t=i+7.
- array_en high for 15+16=31 consecutive cycles.
- batch_done pulses on the 32nd cycle after STREAM start.
REQ-037 Assert rst_n low at t=5 of STREAM:
- All outputs 0 asynchronously.
- in_ready=0 while reset is held, 1 after release.
- A new 16-beat batch streams correctly.
REQ-038 Hold in_valid high with a sequence counter as data across two batches:
- Beats 0..15 and 16..31 are consumed in order.
- in_ready=0 for all 31 busy cycles.
